// File: rtl/motoro_ramp_ctrl_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// motoro_ramp_ctrl_if : command valid/ready channel into the ramp sequencer.
// Rev 1.0
// ----------------------------------------------------------------------------
interface motoro_ramp_ctrl_if;
  logic       cmdValid;
  logic       cmdReady;
  logic [9:0] cmdFreq;
  logic       cmdDir;
  logic       cmdStop;

  modport master (
    output cmdValid,
    output cmdFreq,
    output cmdDir,
    output cmdStop,
    input  cmdReady
  );

  modport slave (
    input  cmdValid,
    input  cmdFreq,
    input  cmdDir,
    input  cmdStop,
    output cmdReady
  );
endinterface
`default_nettype wire

// File: rtl/motoro_ramp_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// motoro_ramp_ctrl : speed ramp + direction sequencer with zero-speed dwell.
// Optional fault input path enabled by MOTORO_RAMP_FAULT_EN.       Rev 1.0
// ----------------------------------------------------------------------------
module motoro_ramp_ctrl #(
  parameter int STEP_TICKS = 50000,
  parameter int F_MIN      = 10,
  parameter int DEAD_TICKS = 500000
) (
  input  wire               clk50mhz,
  input  wire               nReset,
  motoro_ramp_ctrl_if.slave cmd,
`ifdef MOTORO_RAMP_FAULT_EN
  input  wire               faultIn,
  input  wire               faultClr,
`endif
  output logic              m3start,
  output logic [9:0]        m3freq,
  output logic              m3invOrStop,
  output logic              busy,
  output logic [2:0]        state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RAMP  = 3'd1,
    S_RUN   = 3'd2,
    S_DWELL = 3'd3,
    S_FAULT = 3'd4
  } state_t;

  localparam int               CNT_MAX   = (STEP_TICKS > DEAD_TICKS) ? STEP_TICKS : DEAD_TICKS;
  localparam int               CNT_W     = $clog2(CNT_MAX + 1);
  localparam logic [9:0]       FMIN      = 10'(F_MIN);
  localparam logic [CNT_W-1:0] STEP_LAST = CNT_W'(STEP_TICKS - 1);
  localparam logic [CNT_W-1:0] DEAD_LAST = CNT_W'(DEAD_TICKS - 1);

  state_t           state_q, state_d;
  logic             start_q, start_d;
  logic [9:0]       freq_q, freq_d;
  logic             inv_q, inv_d;
  logic             ready_q, ready_d;
  logic             busy_q, busy_d;
  logic [9:0]       tgt_q, tgt_d;
  logic             pend_vld_q, pend_vld_d;
  logic             pend_dir_q, pend_dir_d;
  logic [9:0]       pend_freq_q, pend_freq_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             accept;
  logic             cmd_is_stop;
  logic [9:0]       cmd_tgt;
  logic             tick;
  logic             dwell_done;
  logic [9:0]       freq_step;

  assign accept      = cmd.cmdValid & ready_q;
  assign cmd_is_stop = cmd.cmdStop | (cmd.cmdFreq == 10'd0);
  assign cmd_tgt     = cmd_is_stop ? 10'd0 : ((cmd.cmdFreq < FMIN) ? FMIN : cmd.cmdFreq);
  assign tick        = (cnt_q == STEP_LAST);
  assign dwell_done  = (cnt_q == DEAD_LAST);

  always_comb begin
    state_d     = state_q;
    start_d     = start_q;
    freq_d      = freq_q;
    inv_d       = inv_q;
    tgt_d       = tgt_q;
    pend_vld_d  = pend_vld_q;
    pend_dir_d  = pend_dir_q;
    pend_freq_d = pend_freq_q;
    freq_step   = (freq_q < tgt_q) ? (freq_q + 10'd1) : (freq_q - 10'd1);

    // The counter free-runs only where it means something: step ticks in RAMP, dwell time in DWELL.
    if (state_q == S_RAMP) begin
      cnt_d = tick ? '0 : (cnt_q + 1'b1);
    end else if (state_q == S_DWELL) begin
      cnt_d = cnt_q + 1'b1;
    end else begin
      cnt_d = '0;
    end

    case (state_q)
      S_IDLE: begin
        if (accept && !cmd_is_stop) begin
          start_d    = 1'b1;
          freq_d     = FMIN;
          inv_d      = cmd.cmdDir;
          tgt_d      = cmd_tgt;
          pend_vld_d = 1'b0;
          state_d    = S_RAMP;
          cnt_d      = '0;
        end
      end

      S_RAMP, S_RUN: begin
        if (accept) begin
          cnt_d = '0;
          if (cmd_is_stop) begin
            tgt_d      = 10'd0;
            pend_vld_d = 1'b0;
            state_d    = S_RAMP;
          end else if (cmd.cmdDir != inv_q) begin
            // Reversal: spin down to zero first, the new request waits in the pending slot.
            pend_vld_d  = 1'b1;
            pend_dir_d  = cmd.cmdDir;
            pend_freq_d = cmd_tgt;
            tgt_d       = 10'd0;
            state_d     = S_RAMP;
          end else begin
            tgt_d      = cmd_tgt;
            pend_vld_d = 1'b0;
            state_d    = (cmd_tgt == freq_q) ? S_RUN : S_RAMP;
          end
        end else if (state_q == S_RAMP) begin
          if ((tgt_q != 10'd0) && (freq_q == tgt_q)) begin
            state_d = S_RUN;
            cnt_d   = '0;
          end else if (tick) begin
            if (tgt_q == 10'd0) begin
              if (freq_q <= FMIN) begin
                // Direction may only flip while the core is disabled.
                freq_d  = 10'd0;
                start_d = 1'b0;
                if (pend_vld_q) begin
                  inv_d = pend_dir_q;
                end
                state_d = S_DWELL;
                cnt_d   = '0;
              end else begin
                freq_d = freq_q - 10'd1;
              end
            end else begin
              freq_d = freq_step;
              if (freq_step == tgt_q) begin
                state_d = S_RUN;
              end
            end
          end
        end
      end

      S_DWELL: begin
        if (dwell_done) begin
          cnt_d = '0;
          if (pend_vld_q) begin
            start_d    = 1'b1;
            freq_d     = FMIN;
            inv_d      = pend_dir_q;
            tgt_d      = pend_freq_q;
            pend_vld_d = 1'b0;
            state_d    = S_RAMP;
          end else begin
            tgt_d   = 10'd0;
            state_d = S_IDLE;
          end
        end
      end

`ifdef MOTORO_RAMP_FAULT_EN
      S_FAULT: begin
        if (faultClr && !faultIn) begin
          state_d = S_DWELL;
          cnt_d   = '0;
        end
      end
`endif

      default: begin
        state_d = S_IDLE;
      end
    endcase

`ifdef MOTORO_RAMP_FAULT_EN
    // Fault wins over everything, including a command accepted this cycle.
    if (faultIn) begin
      start_d    = 1'b0;
      freq_d     = 10'd0;
      tgt_d      = 10'd0;
      pend_vld_d = 1'b0;
      state_d    = S_FAULT;
      cnt_d      = '0;
    end
`endif

    ready_d = (state_d == S_IDLE) || (state_d == S_RAMP) || (state_d == S_RUN);
    busy_d  = (state_d == S_RAMP) || (state_d == S_DWELL);
  end

  always_ff @(posedge clk50mhz or negedge nReset) begin
    if (!nReset) begin
      state_q     <= S_IDLE;
      start_q     <= 1'b0;
      freq_q      <= 10'd0;
      inv_q       <= 1'b0;
      ready_q     <= 1'b1;
      busy_q      <= 1'b0;
      tgt_q       <= 10'd0;
      pend_vld_q  <= 1'b0;
      pend_dir_q  <= 1'b0;
      pend_freq_q <= 10'd0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      start_q     <= start_d;
      freq_q      <= freq_d;
      inv_q       <= inv_d;
      ready_q     <= ready_d;
      busy_q      <= busy_d;
      tgt_q       <= tgt_d;
      pend_vld_q  <= pend_vld_d;
      pend_dir_q  <= pend_dir_d;
      pend_freq_q <= pend_freq_d;
      cnt_q       <= cnt_d;
    end
  end

  assign cmd.cmdReady = ready_q;
  assign m3start      = start_q;
  assign m3freq       = freq_q;
  assign m3invOrStop  = inv_q;
  assign busy         = busy_q;
  assign state        = state_q;

endmodule
`default_nettype wire

// File: tb/tb_motoro_ramp_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_motoro_ramp_ctrl : directed + random commands against a timing-formula model.
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_motoro_ramp_ctrl;
  localparam int S  = 4;
  localparam int FM = 10;
  localparam int DT = 20;

  localparam int M_NOP   = 0;
  localparam int M_START = 1;
  localparam int M_RET   = 2;
  localparam int M_STOP  = 3;
  localparam int M_REV   = 4;

  logic       clk = 1'b0;
  logic       nReset;
  logic       m3start;
  logic [9:0] m3freq;
  logic       m3inv;
  logic       busy;
  logic [2:0] state;
`ifdef MOTORO_RAMP_FAULT_EN
  logic       faultIn;
  logic       faultClr;
`endif

  motoro_ramp_ctrl_if cmd_if ();

  motoro_ramp_ctrl #(
    .STEP_TICKS (S),
    .F_MIN      (FM),
    .DEAD_TICKS (DT)
  ) dut (
    .clk50mhz    (clk),
    .nReset      (nReset),
    .cmd         (cmd_if),
`ifdef MOTORO_RAMP_FAULT_EN
    .faultIn     (faultIn),
    .faultClr    (faultClr),
`endif
    .m3start     (m3start),
    .m3freq      (m3freq),
    .m3invOrStop (m3inv),
    .busy        (busy),
    .state       (state)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cur_f = 0;
  bit cur_d = 1'b0;
  int m_mode, m_f0, m_T, m_K0;
  bit m_d0, m_d1;

  // Packed view: {state[16:14], ready[13], busy[12], start[11], inv[10], freq[9:0]}
  function automatic logic [16:0] pk(input int st, input bit rdy, input bit bz,
                                     input bit on, input bit inv, input int f);
    return {3'(st), rdy, bz, on, inv, 10'(f)};
  endfunction

  function automatic logic [16:0] obs();
    return {state, cmd_if.cmdReady, busy, m3start, m3inv, m3freq};
  endfunction

  function automatic int up_len(input int T);
    return ((T - FM) * S > 0) ? (T - FM) * S : 1;
  endfunction

  function automatic logic [16:0] ramp_up(input int k, input int base, input int T, input bit d);
    int  j, f;
    bit  mov;
    j   = (k - base) / S;
    f   = FM + ((j < T - FM) ? j : T - FM);
    mov = (k < base + up_len(T));
    return pk(mov ? 1 : 2, 1'b1, mov, 1'b1, d, f);
  endfunction

  function automatic int settle();
    int n, r;
    n = (m_T > m_f0) ? m_T - m_f0 : m_f0 - m_T;
    case (m_mode)
      M_NOP:   r = 1;
      M_START: r = 1 + up_len(m_T);
      M_RET:   r = 1 + n * S;
      M_STOP:  r = m_K0 + DT;
      default: r = m_K0 + DT + up_len(m_T);
    endcase
    return r;
  endfunction

  function automatic logic [16:0] exp_at(input int k);
    int          j, n, s, f;
    bit          mov;
    logic [16:0] r;
    n = (m_T > m_f0) ? m_T - m_f0 : m_f0 - m_T;
    case (m_mode)
      M_NOP:   r = pk(0, 1'b1, 1'b0, 1'b0, m_d0, 0);
      M_START: r = ramp_up(k, 1, m_T, m_d1);
      M_RET: begin
        j   = (k - 1) / S;
        s   = (j < n) ? j : n;
        f   = (m_T > m_f0) ? m_f0 + s : m_f0 - s;
        mov = (k < 1 + n * S);
        r   = pk(mov ? 1 : 2, 1'b1, mov, 1'b1, m_d0, f);
      end
      default: begin
        if (k < m_K0)
          r = pk(1, 1'b1, 1'b1, 1'b1, m_d0, m_f0 - (k - 1) / S);
        else if (k < m_K0 + DT)
          r = pk(3, 1'b0, 1'b1, 1'b0, (m_mode == M_REV) ? m_d1 : m_d0, 0);
        else if (m_mode == M_REV)
          r = ramp_up(k, m_K0 + DT, m_T, m_d1);
        else
          r = pk(0, 1'b1, 1'b0, 1'b0, m_d0, 0);
      end
    endcase
    return r;
  endfunction

  task automatic check(input string tag, input int k, input logic [16:0] o, input logic [16:0] e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s k=%0d observed=%h expected=%h", tag, k, o, e);
    end
  endtask

  // Called at a negedge; the command is accepted on the following posedge.
  task automatic issue(input int f, input bit d, input bit s);
    int T;
    total++;
    assert (cmd_if.cmdReady === 1'b1) else begin
      bad++;
      $error("FAIL ready_before_cmd observed=%b expected=1", cmd_if.cmdReady);
    end
    T    = (s || f == 0) ? 0 : ((f < FM) ? FM : f);
    m_f0 = cur_f;
    m_d0 = cur_d;
    m_T  = T;
    m_d1 = d;
    if (cur_f == 0)   m_mode = (T == 0) ? M_NOP : M_START;
    else if (T == 0)  m_mode = M_STOP;
    else if (d != cur_d) m_mode = M_REV;
    else              m_mode = M_RET;
    m_K0 = (cur_f - FM + 1) * S + 1;
    cmd_if.cmdValid = 1'b1;
    cmd_if.cmdFreq  = 10'(f);
    cmd_if.cmdDir   = d;
    cmd_if.cmdStop  = s;
    @(posedge clk);
    #1;
    cmd_if.cmdValid = 1'b0;
    cmd_if.cmdFreq  = 10'($urandom_range(0, 1023));
    cmd_if.cmdDir   = 1'($urandom_range(0, 1));
    cmd_if.cmdStop  = 1'($urandom_range(0, 1));
  endtask

  task automatic run(input string tag, input int n);
    logic [16:0] last;
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      check(tag, k, obs(), exp_at(k));
    end
    last  = exp_at(n);
    cur_f = int'(last[9:0]);
    cur_d = last[10];
  endtask

  task automatic run_full(input string tag);
    run(tag, settle() + 2);
  endtask

  initial begin
    int          f, len;
    bit          d, s;
    logic [16:0] tmp;

    cmd_if.cmdValid = 1'b0;
    cmd_if.cmdFreq  = 10'd0;
    cmd_if.cmdDir   = 1'b0;
    cmd_if.cmdStop  = 1'b0;
`ifdef MOTORO_RAMP_FAULT_EN
    faultIn  = 1'b0;
    faultClr = 1'b0;
`endif
    nReset = 1'b1;
    #2 nReset = 1'b0;
    #1 check("reset", 0, obs(), pk(0, 1'b1, 1'b0, 1'b0, 1'b0, 0));
    repeat (2) @(negedge clk);
    nReset = 1'b1;

    issue(20, 1'b0, 1'b0); run_full("t1_start20");
    issue(15, 1'b0, 1'b0); run_full("t2_down15");
    issue(5,  1'b0, 1'b0); run_full("t2_clamp");
    issue(20, 1'b0, 1'b0); run_full("t3_up20");
    issue(0,  1'b0, 1'b1); run_full("t3_stop");
    issue(20, 1'b0, 1'b0); run_full("t4_up20");
    issue(12, 1'b1, 1'b0); run_full("t4_reverse");
    issue(0,  1'b1, 1'b1); run_full("t5_stop");
    issue(0,  1'b0, 1'b1); run_full("t5_idle_stop");
    issue(20, 1'b0, 1'b0); run("t5_up14", 17);
    issue(30, 1'b0, 1'b0); run_full("t5_to30");
    issue(12, 1'b0, 1'b0); run("t5_partial", 9);

    #2 nReset = 1'b0;
    #1 check("async_reset", 0, obs(), pk(0, 1'b1, 1'b0, 1'b0, 1'b0, 0));
    @(negedge clk);
    nReset = 1'b1;
    cur_f  = 0;
    cur_d  = 1'b0;

`ifdef MOTORO_RAMP_FAULT_EN
    issue(20, 1'b0, 1'b0); run("t6_up18", 33);
    faultIn = 1'b1;
    @(negedge clk);
    check("t6_fault", 0, obs(), pk(4, 1'b0, 1'b0, 1'b0, 1'b0, 0));
    faultClr = 1'b1;
    @(negedge clk);
    check("t6_clr_ignored", 0, obs(), pk(4, 1'b0, 1'b0, 1'b0, 1'b0, 0));
    faultIn = 1'b0;
    @(posedge clk);
    #1 faultClr = 1'b0;
    for (int k = 1; k <= DT; k++) begin
      @(negedge clk);
      check("t6_dwell", k, obs(), pk(3, 1'b0, 1'b1, 1'b0, 1'b0, 0));
    end
    @(negedge clk);
    check("t6_idle", 0, obs(), pk(0, 1'b1, 1'b0, 1'b0, 1'b0, 0));
    cur_f = 0;
    cur_d = 1'b0;
`endif

    for (int it = 0; it < 14; it++) begin
      f = int'($urandom_range(0, 40));
      d = 1'($urandom_range(0, 1));
      s = ($urandom_range(0, 9) < 2);
      issue(f, d, s);
      len = settle() + 2;
      if ($urandom_range(0, 2) == 0) begin
        len = int'($urandom_range(1, settle()));
        tmp = exp_at(len);
        if (tmp[13] == 1'b0) len = settle() + 2;
      end
      run("random", len);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire
